apb_slave_regfile: RTL and testbench

//  APB responder (completer) terminating one Pselx line driven by the AHB-to-APB bridge controller.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_regfile.sv | 40 ++++
 rtl/apb_slave_regfile.sv | 131 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, select width, FSM encoding and the
// default content of the read-only identification register.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int PSEL_W = 3;

    localparam logic [APB_DW-1:0] APB_ID_VALUE = 32'hA9B0_0001;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32-bit register file: one synchronous write port, one combinational
// read port, asynchronous clear. Index 0 always reads the ID constant.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int               DEPTH    = 16,
    parameter logic [APB_DW-1:0] ID_VALUE = APB_ID_VALUE,
    parameter int               IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [APB_DW-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [APB_DW-1:0] rdata_o
);

    logic [APB_DW-1:0] mem_q [DEPTH];

    // Storage: cleared asynchronously, one word written per enabled cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: register 0 is a fixed identification word.
    always_comb begin
        rdata_o = mem_q[raddr_i];
        if (raddr_i == '0) begin
            rdata_o = ID_VALUE;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer behind one Pselx line: register file with programmable wait
// states and error response for misaligned, out-of-range and read-only writes.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                SLAVE_ID    = 0,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_STATES = 0,
    parameter logic [APB_DW-1:0] ID_VALUE    = APB_ID_VALUE
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic [PSEL_W-1:0] Pselx,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [APB_AW-1:0] Paddr,
    input  logic [APB_DW-1:0] Pwdata,
    output logic [APB_DW-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);
    localparam logic [3:0] WS_L    = 4'(WAIT_STATES);

    apb_state_e  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [7:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic              sel;
    logic              complete;
    logic              setup_err;
    logic              we;
    logic [APB_DW-1:0] rf_rdata;
    logic              unused_bits;

    assign sel = Pselx[SLAVE_ID];

    // Upper address bits were already decoded by the bridge into Pselx.
    assign unused_bits = ^{Paddr[31:10], Pselx};

    // Error classification of the address/direction seen in the setup phase.
    always_comb begin
        setup_err = (Paddr[1:0] != 2'b00)
                 || ({1'b0, Paddr[9:2]} >= DEPTH_L)
                 || (Pwrite && (Paddr[9:2] == 8'd0));
    end

    // Completion happens in ACCESS once the wait counter has drained,
    // provided the bridge is still holding the transfer.
    assign complete = (state_q == ST_ACCESS) && sel && Penable && (wcnt_q == 4'd0);
    assign we       = complete && write_q && !err_q;

    // Control and latched-transfer registers, cleared asynchronously.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: setup latches the transfer, access counts down
    // wait states, and a dropped select/enable abandons the transfer.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sel && !Penable) begin
                    idx_d   = Paddr[9:2];
                    write_d = Pwrite;
                    err_d   = setup_err;
                    wcnt_d  = WS_L;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sel && Penable) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response outputs are driven only in the completion cycle.
    always_comb begin
        Pready  = complete;
        Pslverr = complete && err_q;
        Prdata  = '0;
        if (complete && !write_q && !err_q) begin
            Prdata = rf_rdata;
        end
    end

    apb_regfile #(
        .DEPTH    (DEPTH),
        .ID_VALUE (ID_VALUE),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i   (Hclk),
        .rst_i   (Hreset),
        .we_i    (we),
        .waddr_i (idx_q[IDX_W-1:0]),
        .wdata_i (Pwdata),
        .raddr_i (idx_q[IDX_W-1:0]),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers on one APB bus (SLAVE_ID 0/1/2 with
// 0/3/2 wait states). The driver queues expected responses; a monitor
// compares every response the DUTs present.
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b0;
    logic [2:0]  Pselx = '0;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = '0;
    logic [31:0] Pwdata = '0;

    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.SLAVE_ID(0), .DEPTH(16), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

    apb_slave_regfile #(.SLAVE_ID(1), .DEPTH(16), .WAIT_STATES(3), .ID_VALUE(ID)) dut1 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

    apb_slave_regfile #(.SLAVE_ID(2), .DEPTH(16), .WAIT_STATES(2), .ID_VALUE(ID)) dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

    typedef struct {
        int          slv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every Pready pops one expected response; otherwise outputs must be 0.
    always @(negedge Hclk) begin
        for (int i = 0; i < 3; i++) begin
            if (pready[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_response: slave %0d got Pready=1 expected none at %0t", i, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_slave", i, mon_e.slv);
                    check("Prdata", prdata[i], mon_e.rdata);
                    check("Pslverr", {31'b0, pslverr[i]}, {31'b0, mon_e.err});
                end
            end else begin
                check("idle_Prdata", prdata[i], 32'h0);
                check("idle_Pslverr", {31'b0, pslverr[i]}, 32'h0);
            end
        end
    end

    // One complete APB transfer; the expected response goes to the scoreboard.
    task automatic xfer(input int slv, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_waits);
        int waits = 0;
        bit done  = 0;
        @(posedge Hclk); #1;
        Pselx   = 3'(1 << slv);
        Penable = 1'b0;
        Paddr   = addr;
        Pwrite  = wr;
        Pwdata  = wdata;
        sb.push_back('{slv, exp_rd, exp_err});
        @(posedge Hclk); #1;
        Penable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Hclk);
            if (pready[slv] === 1'b1) begin
                done = 1;
            end else begin
                waits++;
                @(posedge Hclk); #1;
            end
        end
        @(posedge Hclk); #1;
        Pselx   = '0;
        Penable = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: slave %0d addr %h got no Pready expected one within 40 cycles", slv, addr);
        end else begin
            check("latency", waits, exp_waits);
        end
    endtask

    initial begin
        #1 Hreset = 1'b1;
        repeat (3) @(posedge Hclk);
        #1 Hreset = 1'b0;

        // Reset asserted in the completion cycle of a write aborts it.
        @(posedge Hclk); #1;
        Pselx = 3'b001; Penable = 1'b0; Paddr = 32'h4; Pwrite = 1'b1; Pwdata = 32'h1111_1111;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        #1;
        check("pre_reset_Pready", {31'b0, pready[0]}, 32'h1);
        Hreset = 1'b1;
        #1;
        check("reset_Pready", {31'b0, pready[0]}, 32'h0);
        check("reset_Pslverr", {31'b0, pslverr[0]}, 32'h0);
        check("reset_Prdata", prdata[0], 32'h0);
        @(posedge Hclk); #1;
        Pselx = '0; Penable = 1'b0; Hreset = 1'b0;
        xfer(0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 0);

        // Zero wait states: write then read back.
        xfer(0, 32'h4, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xfer(0, 32'h4, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(0, 32'h3C, 1'b0, 32'h0, 32'h0, 1'b0, 0);

        // Three wait states: ID register.
        xfer(1, 32'h0, 1'b0, 32'h0, ID, 1'b0, 3);

        // Error responses on slave 0.
        xfer(0, 32'h0, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 0);
        xfer(0, 32'h2, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        xfer(0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        xfer(0, 32'h6, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        xfer(0, 32'h0, 1'b0, 32'h0, ID, 1'b0, 0);
        xfer(0, 32'h4, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Enable without a setup phase is ignored.
        @(posedge Hclk); #1;
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h8; Pwdata = 32'hFFFF_0000;
        repeat (3) @(posedge Hclk);
        #1 Pselx = '0; Penable = 1'b0;
        xfer(0, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 0);

        // Upper address bits are ignored.
        xfer(0, 32'h0000_0408, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        xfer(0, 32'h8, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

        // Abort: select dropped in the second access cycle.
        @(posedge Hclk); #1;
        Pselx = 3'b100; Penable = 1'b0; Paddr = 32'h8; Pwrite = 1'b1; Pwdata = 32'hCAFE_CAFE;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Pselx = '0;
        @(posedge Hclk); #1;
        Penable = 1'b0;
        xfer(2, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 2);
        xfer(2, 32'hC, 1'b1, 32'h5A5A_5A5A, 32'h0, 1'b0, 2);
        xfer(2, 32'hC, 1'b0, 32'h0, 32'h5A5A_5A5A, 1'b0, 2);

        // Other select: slave 1 traffic leaves slave 0 untouched.
        xfer(1, 32'h4, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 3);
        xfer(1, 32'h4, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 3);
        xfer(0, 32'h4, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        repeat (5) @(posedge Hclk);
        #1;
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
